// File: rtl/tm_lif_pkg.sv
// Shared helpers and defaults for the time-multiplexed LIF neuron array.
// The refractory feature is enabled by defining TM_LIF_REFRACTORY_EN.
package tm_lif_pkg;

    localparam int N_DEF           = 8;
    localparam int W_DEF           = 8;
    localparam int THRESH_INIT_DEF = 127;

    // Bits needed to index `value` entries; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Unsigned add of two w-bit operands, clamped to 2^w-1 instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        if (sum > max) begin
            return max[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/tm_lif_array_if.sv
// Bus bundle between the neuron array, its current source/configurator and the spike consumer.
interface tm_lif_array_if #(
    parameter int N = tm_lif_pkg::N_DEF,
    parameter int W = tm_lif_pkg::W_DEF
) ();
    localparam int SW = tm_lif_pkg::clog2(N);

    logic          en;
    logic [W-1:0]  current;
    logic          cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic [SW-1:0] slot;
    logic [N-1:0]  spike;
    logic          out_valid;
    logic [SW-1:0] out_slot;
    logic [W-1:0]  state;
    logic          frame_done;

    modport master (
        output en, current, cfg_we, cfg_addr, cfg_data,
        input  slot, spike, out_valid, out_slot, state, frame_done
    );

    modport slave (
        input  en, current, cfg_we, cfg_addr, cfg_data,
        output slot, spike, out_valid, out_slot, state, frame_done
    );
endinterface

// File: rtl/lif_update_unit.sv
// Combinational leak/integrate/fire step for one neuron visit.
// Refractory ports exist only when TM_LIF_REFRACTORY_EN is defined.
module lif_update_unit
    import tm_lif_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int LEAK_SHIFT = 1
`ifdef TM_LIF_REFRACTORY_EN
    ,parameter int REFRAC_VISITS = 2
    ,parameter int RCW           = 2
`endif
) (
    input  logic [W-1:0]   i_v,
    input  logic [W-1:0]   i_current,
    input  logic [W-1:0]   i_thr,
`ifdef TM_LIF_REFRACTORY_EN
    input  logic [RCW-1:0] i_rc,
    output logic [RCW-1:0] o_rc_next,
`endif
    output logic [W-1:0]   o_v_next,
    output logic           o_fire
);
    logic [W-1:0] w_leaked;
    logic [W-1:0] w_sum;

    // Leak, saturating integrate and threshold compare.
    always_comb begin
        w_leaked = i_v >> LEAK_SHIFT;
        w_sum    = W'(sat_add(32'(i_current), 32'(w_leaked), W));
`ifdef TM_LIF_REFRACTORY_EN
        if (i_rc != RCW'(0)) begin
            o_fire    = 1'b0;
            o_v_next  = '0;
            o_rc_next = i_rc - RCW'(1);
        end else begin
            o_fire    = (w_sum >= i_thr);
            o_v_next  = o_fire ? '0 : w_sum;
            o_rc_next = o_fire ? RCW'(REFRAC_VISITS) : RCW'(0);
        end
`else
        o_fire   = (w_sum >= i_thr);
        o_v_next = o_fire ? '0 : w_sum;
`endif
    end
endmodule

// File: rtl/tm_lif_array.sv
// Array of N LIF neurons sharing one update unit, visited round-robin on enabled cycles.
// Optional per-neuron refractory counters: define TM_LIF_REFRACTORY_EN.
module tm_lif_array
    import tm_lif_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int W           = W_DEF,
    parameter int LEAK_SHIFT  = 1,
    parameter int THRESH_INIT = THRESH_INIT_DEF
`ifdef TM_LIF_REFRACTORY_EN
    ,parameter int REFRAC_VISITS = 2
`endif
) (
    input logic          clk,
    input logic          rst_n,
    tm_lif_array_if.slave bus
);
    localparam int SW = clog2(N);
`ifdef TM_LIF_REFRACTORY_EN
    localparam int RCW = clog2(REFRAC_VISITS + 1);
    logic [RCW-1:0] r_rc [N];
    logic [RCW-1:0] w_rc_next;
`endif

    logic [W-1:0]  r_v   [N];
    logic [W-1:0]  r_thr [N];
    logic [SW-1:0] r_slot;
    logic [N-1:0]  r_spike;
    logic          r_out_valid;
    logic [SW-1:0] r_out_slot;
    logic [W-1:0]  r_state;
    logic          r_frame_done;
    logic [W-1:0]  w_v_next;
    logic          w_fire;
    logic          w_last;

    assign w_last = (r_slot == SW'(N - 1));

    lif_update_unit #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT)
`ifdef TM_LIF_REFRACTORY_EN
        ,.REFRAC_VISITS (REFRAC_VISITS)
        ,.RCW           (RCW)
`endif
    ) u_update (
        .i_v       (r_v[r_slot]),
        .i_current (bus.current),
        .i_thr     (r_thr[r_slot]),
`ifdef TM_LIF_REFRACTORY_EN
        .i_rc      (r_rc[r_slot]),
        .o_rc_next (w_rc_next),
`endif
        .o_v_next  (w_v_next),
        .o_fire    (w_fire)
    );

    // Threshold table; the update reads the pre-write value in a collision cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_thr[i] <= W'(THRESH_INIT);
        end else if (bus.cfg_we && (32'(bus.cfg_addr) < N)) begin
            r_thr[bus.cfg_addr] <= bus.cfg_data;
        end else begin
            r_thr <= r_thr;
        end
    end

    // Membrane state, visit counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_v[i] <= '0;
`ifdef TM_LIF_REFRACTORY_EN
            for (int i = 0; i < N; i++) r_rc[i] <= '0;
`endif
            r_slot       <= '0;
            r_spike      <= '0;
            r_out_valid  <= 1'b0;
            r_out_slot   <= '0;
            r_state      <= '0;
            r_frame_done <= 1'b0;
        end else if (bus.en) begin
            r_v[r_slot]     <= w_v_next;
`ifdef TM_LIF_REFRACTORY_EN
            r_rc[r_slot]    <= w_rc_next;
`endif
            r_spike[r_slot] <= w_fire;
            r_slot          <= w_last ? SW'(0) : r_slot + SW'(1);
            r_out_valid     <= 1'b1;
            r_out_slot      <= r_slot;
            r_state         <= w_v_next;
            r_frame_done    <= w_last;
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign bus.slot       = r_slot;
    assign bus.spike      = r_spike;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_slot   = r_out_slot;
    assign bus.state      = r_state;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_tm_lif_array.sv
// Self-checking bench for tm_lif_array against a per-neuron arithmetic model.
module tb_tm_lif_array;
    import tm_lif_pkg::*;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int LS   = 1;
    localparam int TI   = 127;
    localparam int RV   = 2;
    localparam int SW   = 3;
    localparam int VMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tm_lif_array_if #(.N(N), .W(W)) bus ();

    tm_lif_array #(
        .N(N), .W(W), .LEAK_SHIFT(LS), .THRESH_INIT(TI)
`ifdef TM_LIF_REFRACTORY_EN
        ,.REFRAC_VISITS(RV)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int mv [N];
    int mthr [N];
    int mrc [N];
    logic [N-1:0] mspike;
    int mslot;
    logic e_valid, e_frame;
    int e_slot, e_state;
    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; mthr[i] = TI; mrc[i] = 0;
        end
        mspike = '0; mslot = 0;
        e_valid = 1'b0; e_frame = 1'b0; e_slot = 0; e_state = 0;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.current = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Drive one clock of inputs, then advance the model by the same clock.
    task automatic cycle(input logic en, input int cur, input logic we, input int addr, input int data);
        int s, sum;
        logic fire;
        bus.en = en; bus.current = W'(cur); bus.cfg_we = we;
        bus.cfg_addr = SW'(addr); bus.cfg_data = W'(data);
        @(posedge clk); #1;
        if (en) begin
            s = mslot;
            sum = cur + (mv[s] >> LS);
            if (sum > VMAX) sum = VMAX;
`ifdef TM_LIF_REFRACTORY_EN
            if (mrc[s] > 0) begin
                fire = 1'b0; sum = 0; mrc[s] = mrc[s] - 1;
            end else begin
                fire = (sum >= mthr[s]);
                if (fire) mrc[s] = RV;
            end
`else
            fire = (sum >= mthr[s]);
`endif
            mv[s] = fire ? 0 : sum;
            mspike[s] = fire;
            e_valid = 1'b1; e_slot = s; e_state = mv[s]; e_frame = (s == N - 1);
            mslot = (s + 1) % N;
        end else begin
            e_valid = 1'b0; e_frame = 1'b0;
        end
        if (we && addr < N) mthr[addr] = data;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; #1;
        checks++;
        if (bus.slot !== 3'd0 || bus.spike !== 8'd0 || bus.out_valid !== 1'b0 ||
            bus.out_slot !== 3'd0 || bus.state !== 8'd0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: slot=%0d spike=%h valid=%b oslot=%0d state=%0d frame=%b, required all zero",
                     bus.slot, bus.spike, bus.out_valid, bus.out_slot, bus.state, bus.frame_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_current();
        int frames = 0;
        do_reset();
        for (int i = 0; i < 2 * N; i++) begin
            cycle(1'b1, 0, 1'b0, 0, 0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.state !== 8'd0 || bus.spike !== 8'd0 ||
                bus.out_slot !== SW'(i % N) || bus.frame_done !== ((i % N) == N - 1)) begin
                errors++;
                $display("FAIL zero_current: i=%0d valid=%b state=%0d spike=%h oslot=%0d frame=%b",
                         i, bus.out_valid, bus.state, bus.spike, bus.out_slot, bus.frame_done);
            end
            if (bus.frame_done === 1'b1) frames++;
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL frame_count: got %0d required 2", frames);
        end
    endtask

    task automatic test_integrate();
        do_reset();
        cycle(1'b1, 100, 1'b0, 0, 0);
        checks++;
        if (bus.state !== 8'd100 || bus.spike[0] !== 1'b0) begin
            errors++;
            $display("FAIL integrate_v1: state=%0d spike0=%b required 100/0", bus.state, bus.spike[0]);
        end
        for (int i = 1; i < N; i++) cycle(1'b1, 100, 1'b0, 0, 0);
        cycle(1'b1, 100, 1'b0, 0, 0);
        checks++;
        if (bus.state !== 8'd0 || bus.spike[0] !== 1'b1 || bus.out_slot !== 3'd0) begin
            errors++;
            $display("FAIL integrate_v2: state=%0d spike0=%b oslot=%0d required 0/1/0",
                     bus.state, bus.spike[0], bus.out_slot);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cycle(1'b0, 0, 1'b1, 0, 255);
        cycle(1'b0, 0, 1'b1, 2, 0);
        cycle(1'b1, 200, 1'b0, 0, 0);
        checks++;
        if (bus.state !== 8'd200 || bus.spike[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_load: state=%0d spike0=%b required 200/0", bus.state, bus.spike[0]);
        end
        cycle(1'b1, 0, 1'b0, 0, 0);
        cycle(1'b1, 0, 1'b0, 0, 0);
        checks++;
        if (bus.spike[2] !== 1'b1 || bus.state !== 8'd0) begin
            errors++;
            $display("FAIL thr_zero: spike2=%b state=%0d required 1/0", bus.spike[2], bus.state);
        end
        for (int i = 3; i < N; i++) cycle(1'b1, 0, 1'b0, 0, 0);
        cycle(1'b1, 255, 1'b0, 0, 0);
        checks++;
        if (bus.spike[0] !== 1'b1 || bus.state !== 8'd0) begin
            errors++;
            $display("FAIL sat_fire: spike0=%b state=%0d required 1/0", bus.spike[0], bus.state);
        end
    endtask

    task automatic test_cfg_collision();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, 0, 0);
        cycle(1'b1, 20, 1'b1, 3, 10);
        checks++;
        if (bus.spike[3] !== 1'b0 || bus.state !== 8'd20 || bus.out_slot !== 3'd3) begin
            errors++;
            $display("FAIL cfg_old_thr: spike3=%b state=%0d oslot=%0d required 0/20/3",
                     bus.spike[3], bus.state, bus.out_slot);
        end
        for (int i = 0; i < N - 1; i++) cycle(1'b1, 0, 1'b0, 0, 0);
        cycle(1'b1, 20, 1'b0, 0, 0);
        checks++;
        if (bus.spike[3] !== 1'b1 || bus.state !== 8'd0) begin
            errors++;
            $display("FAIL cfg_new_thr: spike3=%b state=%0d required 1/0", bus.spike[3], bus.state);
        end
    endtask

    task automatic test_en_hold();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 150, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, $urandom_range(0, 255), 1'b1, 6, 5);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.slot !== SW'(3) ||
                bus.state !== W'(e_state) || bus.spike !== mspike || bus.out_slot !== 3'd2) begin
                errors++;
                $display("FAIL en_hold: valid=%b frame=%b slot=%0d state=%0d/%0d spike=%h/%h oslot=%0d",
                         bus.out_valid, bus.frame_done, bus.slot, bus.state, e_state,
                         bus.spike, mspike, bus.out_slot);
            end
        end
        cycle(1'b1, 0, 1'b0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_slot !== 3'd3 || bus.slot !== 3'd4) begin
            errors++;
            $display("FAIL en_resume: valid=%b oslot=%0d slot=%0d required 1/3/4",
                     bus.out_valid, bus.out_slot, bus.slot);
        end
    endtask

    task automatic test_random();
        logic en_r, we_r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en_r = ($urandom_range(0, 3) != 0);
            we_r = ($urandom_range(0, 4) == 0);
            cycle(en_r, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 60),
                  we_r, $urandom_range(0, N - 1), $urandom_range(0, 255));
            checks++;
            if (bus.out_valid !== e_valid || bus.frame_done !== e_frame || bus.slot !== SW'(mslot) ||
                bus.out_slot !== SW'(e_slot) || bus.state !== W'(e_state) || bus.spike !== mspike) begin
                errors++;
                $display("FAIL random: i=%0d valid=%b/%b frame=%b/%b slot=%0d/%0d oslot=%0d/%0d state=%0d/%0d spike=%h/%h",
                         i, bus.out_valid, e_valid, bus.frame_done, e_frame, bus.slot, mslot,
                         bus.out_slot, e_slot, bus.state, e_state, bus.spike, mspike);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 200, 1'b0, 0, 0);
        checks++;
        if (bus.slot !== 3'd5 || bus.spike !== 8'h1f) begin
            errors++;
            $display("FAIL pre_reset: slot=%0d spike=%h required 5/1f", bus.slot, bus.spike);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.slot !== 3'd0 || bus.spike !== 8'd0 || bus.out_valid !== 1'b0 ||
            bus.out_slot !== 3'd0 || bus.state !== 8'd0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: slot=%0d spike=%h valid=%b oslot=%0d state=%0d frame=%b, required all zero",
                     bus.slot, bus.spike, bus.out_valid, bus.out_slot, bus.state, bus.frame_done);
        end
        model_reset();
        bus.en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 50, 1'b0, 0, 0);
        checks++;
        if (bus.out_slot !== 3'd0 || bus.state !== 8'd50 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: oslot=%0d state=%0d valid=%b required 0/50/1",
                     bus.out_slot, bus.state, bus.out_valid);
        end
    endtask

`ifdef TM_LIF_REFRACTORY_EN
    task automatic test_refractory();
        logic [3:0] exp_fire;
        exp_fire = 4'b1001;
        do_reset();
        for (int v = 0; v < 4; v++) begin
            cycle(1'b1, 200, 1'b0, 0, 0);
            checks++;
            if (bus.spike[0] !== exp_fire[v] || bus.state !== 8'd0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL refractory: visit=%0d spike0=%b state=%0d required %b/0",
                         v, bus.spike[0], bus.state, exp_fire[v]);
            end
            for (int i = 1; i < N; i++) cycle(1'b1, 0, 1'b0, 0, 0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_current();
        test_integrate();
        test_saturation();
        test_cfg_collision();
        test_en_hold();
        test_random();
        test_reset_mid();
`ifdef TM_LIF_REFRACTORY_EN
        test_refractory();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
